// File: rtl/mips_pkg.sv
// mips_pkg: shared state, opcode, funct, ALU code and mux-select encodings for the multicycle controller
package mips_pkg;
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_BAD  = 4'b1111;
  localparam logic [1:0] AOP_ADD  = 2'b00;
  localparam logic [1:0] AOP_SUB  = 2'b01;
  localparam logic [1:0] AOP_FN   = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps aluop (00 add, 01 sub, 10 funct) and funct to the 4-bit ALU opCode
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] op_code
);
  logic [3:0] fn_code;
  always_comb begin
    fn_code = ALU_BAD;
    case (funct)
      FN_ADD:  fn_code = ALU_ADD;
      FN_SUB:  fn_code = ALU_SUB;
      FN_AND:  fn_code = ALU_AND;
      FN_OR:   fn_code = ALU_OR;
      FN_NOR:  fn_code = ALU_NOR;
      FN_SLT:  fn_code = ALU_SLT;
      default: fn_code = ALU_BAD;
    endcase
  end
  assign op_code = aluop == AOP_SUB ? ALU_SUB : aluop == AOP_FN ? fn_code : ALU_ADD;
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS Moore control FSM (clk, reset, op, funct, zero in; datapath selects/strobes, pc_en, state out)
module mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] opCode,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] PCSrc,
  output logic       pc_en,
  output logic [3:0] state
);
  state_t state_q, state_d;
  logic [1:0] aluop;
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = (op == OP_LW || op == OP_SW) ? MEMADR :
                         op == OP_RTYPE ? EXEC :
                         op == OP_BEQ ? BRANCH :
                         op == OP_ADDI ? ADDIEX :
                         op == OP_J ? JUMP : FETCH;
      MEMADR:  state_d = op == OP_SW ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      EXEC:    state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk)
    state_q <= reset ? FETCH : state_d;
  assign state    = state_q;
  assign aluop    = state_q == EXEC ? AOP_FN : state_q == BRANCH ? AOP_SUB : AOP_ADD;
  assign ALUSrcA  = state_q inside {MEMADR, ADDIEX, EXEC, BRANCH};
  assign ALUSrcB  = state_q == FETCH ? SRCB_FOUR :
                    state_q == DECODE ? SRCB_IMMSH :
                    state_q inside {MEMADR, ADDIEX} ? SRCB_IMM : SRCB_REG;
  assign IorD     = state_q inside {MEMRD, MEMWR};
  assign IRWrite  = state_q == FETCH;
  assign MemWrite = state_q == MEMWR;
  assign RegDst   = state_q == ALUWB;
  assign MemtoReg = state_q == MEMWB;
  assign RegWrite = state_q inside {MEMWB, ALUWB, ADDIWB};
  assign PCSrc    = state_q == BRANCH ? PC_ALUOUT : state_q == JUMP ? PC_JUMP : PC_ALU;
  assign pc_en    = state_q inside {FETCH, JUMP} || (state_q == BRANCH && zero);
  alu_decoder u_alu_decoder (
    .aluop  (aluop),
    .funct  (funct),
    .op_code(opCode)
  );
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: table-driven, hand-sequenced and randomized checks of mc_control against an instruction-level model
module tb_mc_control;
  import mips_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic zero = 1'b0;
  logic [3:0] opCode, state;
  logic ALUSrcA, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, pc_en;
  logic [1:0] ALUSrcB, PCSrc;
  int pass_cnt = 0;
  int total_cnt = 0;
  typedef struct packed {
    logic [3:0] st;
    logic [3:0] opc;
    logic       srca;
    logic [1:0] srcb;
    logic       iord, irw, mw, rd, m2r, rw;
    logic [1:0] pcsrc;
    logic       pcen;
  } out_t;
  typedef int iq_t[$];
  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         cycles;
    string      name;
  } vec_t;
  out_t obs;
  assign obs = {state, opCode, ALUSrcA, ALUSrcB, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, PCSrc, pc_en};
  mc_control dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .opCode(opCode), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .PCSrc(PCSrc), .pc_en(pc_en), .state(state)
  );
  always #5 clk = ~clk;
  function automatic iq_t seq_of(logic [5:0] o);
    iq_t q;
    case (o)
      6'b100011: q = '{0, 1, 2, 3, 4};
      6'b101011: q = '{0, 1, 2, 5};
      6'b000000: q = '{0, 1, 6, 7};
      6'b000100: q = '{0, 1, 8};
      6'b001000: q = '{0, 1, 9, 10};
      6'b000010: q = '{0, 1, 11};
      default:   q = '{0, 1};
    endcase
    return q;
  endfunction
  function automatic out_t exp_out(int s, logic [5:0] fn, logic z);
    out_t e;
    e = '0;
    e.st = 4'(s);
    e.opc = 4'b0010;
    case (s)
      0: begin e.srcb = 2'b01; e.irw = 1'b1; e.pcen = 1'b1; end
      1: e.srcb = 2'b11;
      2, 9: begin e.srca = 1'b1; e.srcb = 2'b10; end
      3: e.iord = 1'b1;
      4: begin e.m2r = 1'b1; e.rw = 1'b1; end
      5: begin e.iord = 1'b1; e.mw = 1'b1; end
      6: begin
        e.srca = 1'b1;
        e.opc = fn == 6'b100000 ? 4'b0010 : fn == 6'b100010 ? 4'b0110 :
                fn == 6'b100100 ? 4'b0000 : fn == 6'b100101 ? 4'b0001 :
                fn == 6'b100111 ? 4'b1100 : fn == 6'b101010 ? 4'b0111 : 4'b1111;
      end
      7: begin e.rd = 1'b1; e.rw = 1'b1; end
      8: begin e.srca = 1'b1; e.opc = 4'b0110; e.pcsrc = 2'b01; e.pcen = z; end
      10: e.rw = 1'b1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask
  task automatic run_vec(vec_t v);
    iq_t s;
    int cyc;
    s = seq_of(v.op);
    cyc = 0;
    op = v.op;
    funct = v.funct;
    zero = v.zero;
    do begin
      #1;
      check({v.name, " outputs"}, 32'(obs), 32'(exp_out(cyc < s.size() ? s[cyc] : 0, v.funct, v.zero)));
      @(posedge clk);
      #1;
      cyc++;
    end while (state != 4'd0 && cyc < 10);
    check({v.name, " cycles"}, 32'(cyc), 32'(v.cycles));
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t vecs[$];
    logic [5:0] fns[6];
    iq_t rs;
    int idx;
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    vecs.push_back('{6'b100011, 6'b000000, 1'b0, 5, "lw"});
    vecs.push_back('{6'b000000, 6'b101010, 1'b0, 4, "rtype slt"});
    vecs.push_back('{6'b000100, 6'b000000, 1'b1, 3, "beq taken"});
    vecs.push_back('{6'b000100, 6'b000000, 1'b0, 3, "beq not taken"});
    vecs.push_back('{6'b101011, 6'b000000, 1'b1, 4, "sw"});
    vecs.push_back('{6'b111111, 6'b000000, 1'b0, 2, "unknown op"});
    vecs.push_back('{6'b000000, 6'b000000, 1'b0, 4, "rtype bad funct"});
    vecs.push_back('{6'b000000, 6'b100000, 1'b0, 4, "rtype add"});
    vecs.push_back('{6'b000000, 6'b100010, 1'b1, 4, "rtype sub"});
    vecs.push_back('{6'b000000, 6'b100100, 1'b0, 4, "rtype and"});
    vecs.push_back('{6'b000000, 6'b100101, 1'b0, 4, "rtype or"});
    vecs.push_back('{6'b000000, 6'b100111, 1'b0, 4, "rtype nor"});
    vecs.push_back('{6'b001000, 6'b000000, 1'b0, 4, "addi"});
    vecs.push_back('{6'b000010, 6'b000000, 1'b1, 3, "jump"});
    reset = 1'b1;
    op = 6'b100011;
    @(posedge clk);
    #1;
    check("reset cycle 1", 32'(obs), 32'(exp_out(0, 6'd0, 1'b0)));
    @(posedge clk);
    #1;
    check("reset cycle 2", 32'(obs), 32'(exp_out(0, 6'd0, 1'b0)));
    reset = 1'b0;
    foreach (vecs[i]) run_vec(vecs[i]);
    op = 6'b100011;
    funct = 6'd0;
    zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reach memrd", 32'(state), 32'd3);
    reset = 1'b1;
    #1;
    check("memrd outputs under reset", 32'(obs), 32'(exp_out(3, 6'd0, 1'b0)));
    @(posedge clk);
    #1;
    check("reset from memrd", 32'(obs), 32'(exp_out(0, 6'd0, 1'b0)));
    @(posedge clk);
    #1;
    check("reset held", 32'(obs), 32'(exp_out(0, 6'd0, 1'b0)));
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("first clk after reset", 32'(obs), 32'(exp_out(1, 6'd0, 1'b0)));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idx = 0;
    for (int c = 0; c < 400; c++) begin
      if (idx == 0) begin
        case ($urandom_range(0, 6))
          0: op = 6'b100011;
          1: op = 6'b101011;
          2: op = 6'b000000;
          3: op = 6'b000100;
          4: op = 6'b001000;
          5: op = 6'b000010;
          default: op = 6'($urandom);
        endcase
        funct = $urandom_range(0, 1) == 1 ? fns[$urandom_range(0, 5)] : 6'($urandom);
        rs = seq_of(op);
      end
      zero = 1'($urandom);
      reset = $urandom_range(0, 24) == 0;
      #1;
      check("random", 32'(obs), 32'(exp_out(rs[idx], funct, zero)));
      @(posedge clk);
      #1;
      idx = (reset || idx == rs.size() - 1) ? 0 : idx + 1;
    end
    reset = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single rising-edge clock.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port op, input, 6 bits: instruction [31:26], valid from the cycle after IRWrite.
REQ-004 The block SHALL have the port funct, input, 6 bits: instruction [5:0].
REQ-005 The block SHALL have the port zero, input, 1 bit: ALU zero flag, meaning ALU_Out == 0.
REQ-006 The block SHALL have the port opCode, output, 4 bits: ALU op code, with and=0000, or=0001, add=0010, sub=0110, slt=0111, nor=1100.
REQ-007 The block SHALL have the ports ALUSrcA (1 bit) and ALUSrcB (2 bits), outputs: ALU operand selects, SrcB 00=reg, 01=4, 10=signimm, 11=signimm<<2.
REQ-008 The block SHALL have the output ports IorD, IRWrite, MemWrite, RegDst, MemtoReg and RegWrite, 1 bit each: datapath strobes and selects.
REQ-009 The block SHALL have the ports PCSrc (output, 2 bits: 00=ALU, 01=ALUOut, 10=jump) and pc_en (output, 1 bit: PC register enable).
REQ-010 The block SHALL have the port state, output, 4 bits: current FSM state, for debug.

Function
REQ-011 The FSM SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10 and JUMP=11, and SHALL advance one state per clk.
REQ-012 Transitions: FETCH->DECODE; DECODE->MEMADR for lw(100011) or sw(101011), EXEC for R-type(000000), BRANCH for beq(000100), ADDIEX for addi(001000), JUMP for j(000010), and FETCH for any other op.
REQ-013 Transitions: MEMADR->MEMRD for lw, MEMWR for sw; MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, BRANCH and JUMP->FETCH.
REQ-014 Transitions: unencoded state values 12-15 SHALL go to FETCH on the next clk.
REQ-015 Outputs in FETCH: IorD=0, SrcA=0, SrcB=01, add, PCSrc=00, IRWrite=1, pc_en=1.
REQ-016 Outputs in DECODE: SrcA=0, SrcB=11, add.
REQ-017 Outputs in MEMADR and ADDIEX: SrcA=1, SrcB=10, add.
REQ-018 Outputs in MEMRD: IorD=1.
REQ-019 Outputs in MEMWR: IorD=1, MemWrite=1.
REQ-020 Outputs in MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
REQ-021 Outputs in EXEC: SrcA=1, SrcB=00, opCode decoded from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt, any other 1111.
REQ-022 Outputs in ALUWB: RegDst=1, RegWrite=1.
REQ-023 Outputs in ADDIWB: RegWrite=1.
REQ-024 Outputs in BRANCH: SrcA=1, SrcB=00, sub, PCSrc=01, pc_en=zero.
REQ-025 Outputs in JUMP: PCSrc=10, pc_en=1.
REQ-026 Every output not listed for a state SHALL be 0, and opCode SHALL be add (0010) in every state that does not specify it.
REQ-027 pc_en SHALL be the only output with a combinational input path (zero, in BRANCH only); all other outputs SHALL be functions of state, plus funct in EXEC.
REQ-028 Cycle counts SHALL be lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.

Reset
REQ-029 While reset=1 at a clk edge, the state SHALL become FETCH, overriding any transition, including mid-instruction.
REQ-030 While held in reset, outputs SHALL equal the FETCH outputs, including IRWrite=1 and pc_en=1, and datapath reset SHALL dominate.
REQ-031 On the first clk with reset=0, the FSM SHALL advance to DECODE.

Structure
REQ-032 Package mips_pkg SHALL hold the state enum, the op/funct localparams, the ALU opCode localparams and the ALUSrcB/PCSrc encodings.
REQ-033 The funct-to-opCode mapping SHALL be a sub-module alu_decoder (inputs: aluop 2 bits, 00=add, 01=sub, 10=funct; funct), instantiated once.

Verification
REQ-034 Scenario: reset for 2 clk, then op=100011 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-035 Scenario: op=000000, funct=101010 -> EXEC opCode=0111, ALUWB RegDst=1, RegWrite=1, back at FETCH after 4 clk.
REQ-036 Scenario: op=000100 with zero=1, then repeated with zero=0 -> BRANCH pc_en=1 and PCSrc=01 in the first case, pc_en=0 in the second, both back at FETCH.
REQ-037 Scenario: op=101011 -> MEMWR MemWrite=1 and IorD=1 for exactly one cycle, with RegWrite never asserted.
REQ-038 Scenario: op=111111, and separately R-type with funct=000000 -> DECODE->FETCH in the first case, opCode=1111 in EXEC in the second.
REQ-039 Scenario: reset asserted while in MEMRD -> state=0 on the next clk, with MemWrite and RegWrite never asserted.
